// File: rtl/bmp_load_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bmp_load_ctrl
// Description : Sequencer that streams a BMP file from the image ROM into the
//               working RAM, one byte per clock. The read and write stages
//               are pipelined, so a load takes TOTAL_SIZE+2 cycles. The
//               header fields needed downstream are captured as the bytes
//               pass through.
// Optional    : `define BMP_SIG_CHECK_EN enables the "BM" signature check.
//               On a mismatch the load stops after address 1 and hdr_err
//               is raised.
// Ports       : clk, rst_n            - clock, asynchronous active-low reset
//               start                - one-cycle load request (IDLE only)
//               ROM_Q                - ROM data, one cycle after the issue
//               ROM_valid/ROM_addr   - ROM read issue
//               RAM_valid/RAM_addr/RAM_D - RAM write beat
//               busy, done           - status, done is a 1-cycle pulse
//               hdr_err, hdr_valid   - header status flags
//               pix_offset, img_width, img_height - little-endian header
//                                                   fields
// Revision    : 1.0 - initial release
// ============================================================================
module bmp_load_ctrl #(
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 20,
  parameter int TOTAL_SIZE = 786486
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BYTE_WIDTH-1:0] ROM_Q,
  output logic                  ROM_valid,
  output logic [ADDR_WIDTH-1:0] ROM_addr,
  output logic                  RAM_valid,
  output logic [ADDR_WIDTH-1:0] RAM_addr,
  output logic [BYTE_WIDTH-1:0] RAM_D,
  output logic                  busy,
  output logic                  done,
  output logic                  hdr_err,
  output logic                  hdr_valid,
  output logic [31:0]           pix_offset,
  output logic [31:0]           img_width,
  output logic [31:0]           img_height
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COPY  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(TOTAL_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] PIX_BASE    = ADDR_WIDTH'(10);
  localparam logic [ADDR_WIDTH-1:0] WIDTH_BASE  = ADDR_WIDTH'(18);
  localparam logic [ADDR_WIDTH-1:0] HEIGHT_BASE = ADDR_WIDTH'(22);
  localparam logic [ADDR_WIDTH-1:0] HDR_LAST    = ADDR_WIDTH'(25);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                    wr_valid_q, wr_valid_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]             pix_q, pix_d;
  logic [31:0]             wid_q, wid_d;
  logic [31:0]             hgt_q, hgt_d;
  logic                    hdr_valid_q, hdr_valid_d;
  logic [7:0]              hdr_byte;

  // Header fields are byte-lane assembled; only the low byte of the bus is
  // meaningful for file bytes.
  assign hdr_byte = 8'(ROM_Q);

`ifdef BMP_SIG_CHECK_EN
  logic [7:0] byte0_q, byte0_d;
  logic       hdr_err_q, hdr_err_d;
`endif

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      pix_q       <= '0;
      wid_q       <= '0;
      hgt_q       <= '0;
      hdr_valid_q <= 1'b0;
`ifdef BMP_SIG_CHECK_EN
      byte0_q     <= '0;
      hdr_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      pix_q       <= pix_d;
      wid_q       <= wid_d;
      hgt_q       <= hgt_d;
      hdr_valid_q <= hdr_valid_d;
`ifdef BMP_SIG_CHECK_EN
      byte0_q     <= byte0_d;
      hdr_err_q   <= hdr_err_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    pix_d       = pix_q;
    wid_d       = wid_q;
    hgt_d       = hgt_q;
    hdr_valid_d = hdr_valid_q;
`ifdef BMP_SIG_CHECK_EN
    byte0_d     = byte0_q;
    hdr_err_d   = hdr_err_q;
`endif

    // Header capture on the write beat; placed before the state case so a
    // clear on an accepted start always takes priority.
    if (wr_valid_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_addr_q == PIX_BASE + ADDR_WIDTH'(i))    pix_d[8*i +: 8] = hdr_byte;
        if (wr_addr_q == WIDTH_BASE + ADDR_WIDTH'(i))  wid_d[8*i +: 8] = hdr_byte;
        if (wr_addr_q == HEIGHT_BASE + ADDR_WIDTH'(i)) hgt_d[8*i +: 8] = hdr_byte;
      end
      if (wr_addr_q == HDR_LAST) hdr_valid_d = 1'b1;
`ifdef BMP_SIG_CHECK_EN
      if (wr_addr_q == '0) byte0_d = hdr_byte;
`endif
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_COPY;
          rd_addr_d   = '0;
          pix_d       = '0;
          wid_d       = '0;
          hgt_d       = '0;
          hdr_valid_d = 1'b0;
`ifdef BMP_SIG_CHECK_EN
          hdr_err_d   = 1'b0;
`endif
        end
      end
      S_COPY: begin
        // The address issued this cycle becomes next cycle's write beat.
        wr_valid_d = 1'b1;
        wr_addr_d  = rd_addr_q;
        if (rd_addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
`ifdef BMP_SIG_CHECK_EN
        // Beat for address 1 carries the second signature byte. On a bad
        // signature the in-flight read of address 2 is dropped.
        if (wr_valid_q && (wr_addr_q == ADDR_WIDTH'(1)) &&
            ({byte0_q, hdr_byte} != 16'h424D)) begin
          hdr_err_d  = 1'b1;
          wr_valid_d = 1'b0;
          state_d    = S_DRAIN;
        end
`endif
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ROM_valid  = (state_q == S_COPY);
  assign ROM_addr   = ROM_valid ? rd_addr_q : '0;
  assign RAM_valid  = wr_valid_q;
  assign RAM_addr   = wr_valid_q ? wr_addr_q : '0;
  assign RAM_D      = wr_valid_q ? ROM_Q : '0;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign hdr_valid  = hdr_valid_q;
  assign pix_offset = pix_q;
  assign img_width  = wid_q;
  assign img_height = hgt_q;
`ifdef BMP_SIG_CHECK_EN
  assign hdr_err    = hdr_err_q;
`else
  assign hdr_err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bmp_load_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_bmp_load_ctrl
// Description : Directed self-checking bench for bmp_load_ctrl with a
//               64-byte image ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bmp_load_ctrl;

  localparam int N = 64;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  ROM_Q;
  logic        ROM_valid;
  logic [19:0] ROM_addr;
  logic        RAM_valid;
  logic [19:0] RAM_addr;
  logic [7:0]  RAM_D;
  logic        busy;
  logic        done;
  logic        hdr_err;
  logic        hdr_valid;
  logic [31:0] pix_offset;
  logic [31:0] img_width;
  logic [31:0] img_height;

  bmp_load_ctrl #(
    .BYTE_WIDTH (8),
    .ADDR_WIDTH (20),
    .TOTAL_SIZE (N)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ROM_Q      (ROM_Q),
    .ROM_valid  (ROM_valid),
    .ROM_addr   (ROM_addr),
    .RAM_valid  (RAM_valid),
    .RAM_addr   (RAM_addr),
    .RAM_D      (RAM_D),
    .busy       (busy),
    .done       (done),
    .hdr_err    (hdr_err),
    .hdr_valid  (hdr_valid),
    .pix_offset (pix_offset),
    .img_width  (img_width),
    .img_height (img_height)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: synchronous read, data valid the cycle after issue
  logic [7:0] rom [N];
  always @(posedge clk) begin
    if (ROM_valid) ROM_Q <= rom[ROM_addr[5:0]];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor: per-load counters and per-beat checks, sampled on negedge
  // --------------------------------------------------------------------------
  int          n_rd, n_wr, n_done;
  logic [19:0] rd_exp, wr_exp;
  logic        prev_rom_v, prev_ram_v, prev_busy, chk25;
  logic [19:0] prev_ram_addr;
  bit          exp_full = 1'b1;

  always @(negedge clk) begin
    if (!rst_n) begin
      n_rd = 0; n_wr = 0; n_done = 0; rd_exp = '0; wr_exp = '0;
      prev_rom_v = 1'b0; prev_ram_v = 1'b0; prev_busy = 1'b0; chk25 = 1'b0;
      prev_ram_addr = '0;
    end else begin
      if (busy && !prev_busy) begin
        n_rd = 0; n_wr = 0; n_done = 0; rd_exp = '0; wr_exp = '0;
      end
      if (chk25) begin
        check("hdr_valid_rise", hdr_valid, 1);
        chk25 = 1'b0;
      end
      if (ROM_valid) begin
        check("rom_addr", ROM_addr, rd_exp);
        rd_exp++;
        n_rd++;
      end
      if (exp_full) check("ram_lag", RAM_valid, prev_rom_v);
      if (RAM_valid) begin
        check("ram_addr", RAM_addr, wr_exp);
        check("ram_d", RAM_D, rom[RAM_addr[5:0]]);
        if (RAM_addr == 20'd25) begin
          check("hdr_valid_pre", hdr_valid, 0);
          chk25 = 1'b1;
        end
        wr_exp++;
        n_wr++;
      end
      if (done) begin
        n_done++;
        if (exp_full) check("done_after_last", {prev_ram_v, prev_ram_addr == 20'(N-1)}, 2'b11);
      end
      prev_rom_v    = ROM_valid;
      prev_ram_v    = RAM_valid;
      prev_ram_addr = RAM_addr;
      prev_busy     = busy;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers: all actions happen 1 ns after the falling edge
  // --------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic wait_read(input logic [19:0] a);
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (ROM_valid && ROM_addr == a) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("read_timeout", 0, 1);
  endtask

  task automatic check_header();
    check("pix_offset", pix_offset, 32'd54);
    check("img_width",  img_width,  32'd512);
    check("img_height", img_height, 32'd512);
    check("hdr_valid",  hdr_valid,  1);
    check("hdr_err",    hdr_err,    0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {ROM_valid, RAM_valid, busy, done, hdr_err, hdr_valid}, 0);
    check({tag, "_addrs"}, {ROM_addr, RAM_addr}, 0);
    check({tag, "_data"}, RAM_D, 0);
    check({tag, "_fields"}, pix_offset | img_width | img_height, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) rom[i] = 8'(i);
    rom[0]  = 8'h42; rom[1]  = 8'h4D;
    rom[10] = 8'h36; rom[11] = 8'h00; rom[12] = 8'h00; rom[13] = 8'h00;
    rom[18] = 8'h00; rom[19] = 8'h02; rom[20] = 8'h00; rom[21] = 8'h00;
    rom[22] = 8'h00; rom[23] = 8'h02; rom[24] = 8'h00; rom[25] = 8'h00;
    ROM_Q = '0;
    start = 1'b0;
    rst_n = 1'b0;

    // Reset state
    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Full load with start pulses at read 5 and in the done cycle
    pulse_start();
    check("busy_after_start", busy, 1);
    wait_read(20'd5);
    pulse_start();
    wait_done();
    check("done_count_at_done", n_done, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_done", busy, 0);
    repeat (5) step();
    check("idle_stays", busy, 0);
    check("n_rd", n_rd, N);
    check("n_wr", n_wr, N);
    check("n_done", n_done, 1);
    check_header();

    // Reset in the middle of a load
    pulse_start();
    wait_read(20'd30);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    step();
    step();
    rst_n = 1'b1;
    repeat (10) step();
    check("post_reset_writes", n_wr, 0);
    check("post_reset_reads", n_rd, 0);
    check("post_reset_busy", busy, 0);
    pulse_start();
    wait_done();
    step();
    check("reload_n_rd", n_rd, N);
    check("reload_n_wr", n_wr, N);
    check_header();

`ifdef BMP_SIG_CHECK_EN
    // Bad signature "BX"
    exp_full = 1'b0;
    rom[1] = 8'h58;
    pulse_start();
    wait_done();
    check("sig_n_wr", n_wr, 2);
    check("sig_n_rd", n_rd, 3);
    check("sig_hdr_err", hdr_err, 1);
    check("sig_hdr_valid", hdr_valid, 0);
    step();
    check("sig_busy", busy, 0);
    rom[1] = 8'h4D;
    exp_full = 1'b1;
`endif

    // Back-to-back loads
    pulse_start();
    wait_done();
    check("b2b_first_n_wr", n_wr, N);
    step();
    check("b2b_idle_gap", busy, 0);
    pulse_start();
    check("b2b_busy", busy, 1);
    check("b2b_cleared", pix_offset | img_width | img_height, 0);
    check("b2b_hdr_valid_clr", hdr_valid, 0);
    check("b2b_hdr_err_clr", hdr_err, 0);
    wait_done();
    step();
    check("b2b_n_rd", n_rd, N);
    check("b2b_n_wr", n_wr, N);
    check("b2b_n_done", n_done, 1);
    check_header();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
